line_mem_responder: RTL and testbench
=====================================

// Module: line_mem_responder
// PURPOSE
//  Main-memory model answering the instruction/data cache's line-fill port.
//  - Accepts one line read request (32-bit byte address) and returns a full 128-bit line after a fixed latency.
//  - Holds the backing store; a word-granular load port preloads it for programs and benches.
//  - Sits directly on the cache's mem_* interface.
// PARAMETERS
//  LineWords  4    32-bit words per line (line = 128 bits, 16 bytes)
//  MemLines   256  lines in backing store (4 KiB); line index = addr[IdxBits+3:4]
//  Latency    4    cycles from request acceptance to valid pulse; legal range 1..15
//  IdxBits    $clog2(MemLines)  derived localparam, not overridable
// PORTS
//  clk_i             in   1    clock, all logic on rising edge
//  rst_i             in   1    synchronous reset, active-high
//  mem_addr_i        in   32   request byte address; bits [3:0] ignored; bits above index ignored (aliasing)
//  mem_read_en_i     in   1    request strobe, sampled only in IDLE
//  mem_read_valid_o  out  1    one-cycle pulse: mem_read_data_o holds requested line
//  mem_read_data_o   out  128  line, word k at bits [32k+31:32k]
//  busy_o            out  1    high in WAIT and RESP
//  req_dropped_o     out  1    sticky: strobe seen while busy; cleared only by reset
//  load_en_i         in   1    preload write enable
//  load_addr_i       in   32   preload byte address; [1:0] ignored, word = addr[IdxBits+3:2]
//  load_data_i       in   32   preload word
// BEHAVIOUR
//  Reset (rst_i=1 at an edge): state=IDLE; valid_o=0; data_o=0; busy_o=0; req_dropped_o=0; latency counter=0.
//   Array contents NOT reset. In-flight request is abandoned; no valid pulse for it afterwards.
//  FSM: IDLE -> WAIT when mem_read_en_i=1; latch line index, load counter with Latency-1.
//   WAIT: counter decrements each cycle. At counter==0, next edge registers array[index] into data_o,
//   raises valid_o, goes to RESP.
//   RESP: valid_o high exactly this cycle; next edge -> IDLE, valid_o=0.
//   New strobe in RESP is dropped.
//  Timing: strobe high in cycle T (IDLE) -> valid_o high in cycle T+Latency only. Next acceptance at T+Latency+1 at earliest.
//   Back-to-back hits on the cache side need no overlap.
//  data_o holds its last line after valid drops; it changes only at a valid-raising edge or on reset.
//  Strobe while busy_o=1: ignored, req_dropped_o<=1. Requester must wait for valid.
//  Load port: write at every edge with load_en_i=1, in any state.
//   Same-edge load and line capture: capture sees OLD word (read-before-write).
//   Loads committed at earlier edges are visible.
//  Address aliasing: index wraps modulo MemLines; no error raised.
// CONFIGURATION
//  MEM_RESP_JITTER_EN defined:
//   - Counter load becomes Latency-1 + lfsr[1:0], giving latency Latency..Latency+3.
//   - 8-bit Fibonacci LFSR, taps 8,6,5,4, seed 8'hA5 on reset, advances every cycle.
//  Undefined: latency exactly Latency, no LFSR instantiated.
// STRUCTURE
//  Package mem_pkg:
//   - LineSize=128, line_t (logic [127:0]).
//   - resp_state_e {IDLE, WAIT, RESP}.
//   - Shared with the cache so both ends agree on line width.
//  Sub-module lfsr8 (clk_i, rst_i, value_o[7:0]), instantiated only under MEM_RESP_JITTER_EN.
//  Array: single logic [MemLines-1:0][127:0] register, word-write via load port.
// TESTING
//  1. Reset, load line 3 words 0x11,0x22,0x33,0x44 (addrs 0x30..0x3C); strobe addr 0x34 at cycle T
//     -> valid at T+4, data=0x00000044_00000033_00000022_00000011.
//  2. Strobe addr 0x1030 (aliases line 3 with MemLines=256)
//     -> same line as scenario 1, req_dropped_o stays 0.
//  3. Second strobe 2 cycles after first -> ignored, req_dropped_o=1, single valid pulse at T+4.
//  4. Load word 0x34 <= 0xDEADBEEF on the same edge valid rises for line 3
//     -> data word1=0x22; re-request returns 0xDEADBEEF.
//  5. rst_i at T+2 of a request -> no valid pulse in any later cycle, busy_o=0, data_o=0, array contents kept.
//  6. With MEM_RESP_JITTER_EN, 100 requests -> every latency in [4,7], valid width always 1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared line-fill definitions so the cache and the memory model agree on line width.
package mem_pkg;

    localparam int unsigned LineSize = 128;

    typedef logic [LineSize-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_e;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded with 8'hA5 on reset, steps every cycle.
module lfsr8 (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [7:0] value_o
);

    localparam logic [7:0] Seed = 8'hA5;

    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= Seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/line_mem_responder.sv
// Backing-store model for the cache line-fill port: one line read per request, fixed latency.
// Define MEM_RESP_JITTER_EN to add 0..3 cycles of LFSR-driven latency jitter.
module line_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned LineWords = 4,
    parameter int unsigned MemLines  = 256,
    parameter int unsigned Latency   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_read_en_i,
    output logic        mem_read_valid_o,
    output line_t       mem_read_data_o,
    output logic        busy_o,
    output logic        req_dropped_o,
    input  logic        load_en_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i
);

    localparam int unsigned IdxBits  = $clog2(MemLines);
    localparam int unsigned WordBits = $clog2(LineWords);

    resp_state_e        state_q, state_d;
    logic [4:0]         count_q, count_d, count_load;
    logic [IdxBits-1:0] idx_q, idx_d;
    line_t              data_q, data_d;
    logic               valid_q, valid_d;
    logic               dropped_q, dropped_d;

    line_t [MemLines-1:0] mem_q;
    logic [IdxBits-1:0]   load_line;
    logic [WordBits-1:0]  load_word;

    // Offset bits and bits above the index are ignored on purpose (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr_i[31:IdxBits+4], mem_addr_i[3:0],
                                load_addr_i[31:IdxBits+4], load_addr_i[1:0]};

    assign load_line = load_addr_i[IdxBits+3:4];
    assign load_word = load_addr_i[WordBits+1:2];

`ifdef MEM_RESP_JITTER_EN
    logic [7:0] lfsr_value;
    logic       unused_lfsr_bits;

    lfsr8 u_lfsr8 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .value_o (lfsr_value)
    );

    assign unused_lfsr_bits = ^lfsr_value[7:2];
    assign count_load       = 5'(Latency - 1) + {3'b000, lfsr_value[1:0]};
`else
    assign count_load = 5'(Latency - 1);
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        dropped_d = dropped_q;
        case (state_q)
            IDLE: begin
                if (mem_read_en_i) begin
                    state_d = WAIT;
                    idx_d   = mem_addr_i[IdxBits+3:4];
                    count_d = count_load;
                end
            end
            WAIT: begin
                if (mem_read_en_i) begin
                    dropped_d = 1'b1;
                end
                if (count_q == 5'd0) begin
                    // Reads the pre-edge array, so a same-edge load is not seen.
                    data_d  = mem_q[idx_q];
                    valid_d = 1'b1;
                    state_d = RESP;
                end else begin
                    count_d = count_q - 5'd1;
                end
            end
            RESP: begin
                if (mem_read_en_i) begin
                    dropped_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            count_q   <= 5'd0;
            idx_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            dropped_q <= dropped_d;
        end
    end

    // Array contents survive reset; the load port writes in every state.
    always_ff @(posedge clk_i) begin
        if (load_en_i) begin
            mem_q[load_line][{load_word, 5'b00000} +: 32] <= load_data_i;
        end
    end

    assign mem_read_valid_o = valid_q;
    assign mem_read_data_o  = data_q;
    assign busy_o           = (state_q != IDLE);
    assign req_dropped_o    = dropped_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench for line_mem_responder: vector table, directed corner cases, random traffic.
module tb_line_mem_responder;

    localparam int unsigned LineWords = 4;
    localparam int unsigned MemLines  = 256;
    localparam int unsigned Latency   = 4;
    localparam int unsigned NumWords  = LineWords * MemLines;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  mem_addr;
    logic         mem_read_en;
    logic         mem_read_valid;
    logic [127:0] mem_read_data;
    logic         busy;
    logic         req_dropped;
    logic         load_en;
    logic [31:0]  load_addr;
    logic [31:0]  load_data;

    int tests = 0;
    int fails = 0;

    line_mem_responder #(
        .LineWords (LineWords),
        .MemLines  (MemLines),
        .Latency   (Latency)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .mem_addr_i       (mem_addr),
        .mem_read_en_i    (mem_read_en),
        .mem_read_valid_o (mem_read_valid),
        .mem_read_data_o  (mem_read_data),
        .busy_o           (busy),
        .req_dropped_o    (req_dropped),
        .load_en_i        (load_en),
        .load_addr_i      (load_addr),
        .load_data_i      (load_data)
    );

    always #5 clk = ~clk;

    // Reference model: word array plus "request accepted at edge e answers at edge e+Latency".
    logic [31:0]  ref_mem [NumWords];
    bit           m_pend  = 1'b0;
    bit           m_valid = 1'b0;
    bit           m_drop  = 1'b0;
    int unsigned  m_idx   = 0;
    longint       edge_n  = 0;
    longint       m_due   = 0;
    logic [127:0] m_data  = '0;

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [31:0] pat(int unsigned line, int unsigned word);
        return 32'hC0DE_0000 | 32'(line << 4) | 32'(word);
    endfunction

    function automatic logic [127:0] ref_line(logic [31:0] a);
        logic [127:0] l;
        int unsigned  idx;
        idx = int'((a >> 4) % MemLines);
        for (int k = 0; k < LineWords; k++) begin
            l[32*k +: 32] = ref_mem[idx*LineWords + k];
        end
        return l;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advances the model with the inputs the DUT is about to sample.
    task automatic model_step();
        bit busy_before;
        edge_n++;
        if (rst) begin
            m_pend  = 1'b0;
            m_valid = 1'b0;
            m_drop  = 1'b0;
            m_data  = '0;
        end else begin
            busy_before = m_pend || m_valid;
            m_valid     = 1'b0;
            if (m_pend && edge_n == m_due) begin
                m_data  = ref_line(32'(m_idx) << 4);
                m_valid = 1'b1;
                m_pend  = 1'b0;
            end
            if (mem_read_en) begin
                if (busy_before) begin
                    m_drop = 1'b1;
                end else begin
                    m_pend = 1'b1;
                    m_idx  = int'((mem_addr >> 4) % MemLines);
                    m_due  = edge_n + longint'(Latency);
                end
            end
        end
        if (load_en) begin
            ref_mem[(load_addr >> 2) % NumWords] = load_data;
        end
    endtask

    task automatic check_model();
`ifndef MEM_RESP_JITTER_EN
        chk("valid", {127'd0, mem_read_valid}, {127'd0, m_valid});
        chk("busy", {127'd0, busy}, {127'd0, (m_pend || m_valid)});
        chk("dropped", {127'd0, req_dropped}, {127'd0, m_drop});
        chk("data", mem_read_data, m_data);
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic check_lat(input string name, input int lat);
`ifdef MEM_RESP_JITTER_EN
        chk(name, {127'd0, (lat >= int'(Latency) && lat <= int'(Latency) + 3)}, 128'd1);
`else
        chk(name, 128'(lat), 128'(Latency));
`endif
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    // Strobe for one cycle, wait (bounded) for the valid pulse, then return in IDLE.
    task automatic request(input logic [31:0] a, output int lat, output logic [127:0] d);
        mem_read_en = 1'b1;
        mem_addr    = a;
        tick();
        mem_read_en = 1'b0;
        lat = -1;
        d   = '0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (mem_read_valid) begin
                lat = n;
                d   = mem_read_data;
                break;
            end
        end
        tick();
        chk("valid_width", {127'd0, mem_read_valid}, 128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int           lat;
        int           pulses;
        int           first;
        logic [127:0] d;

        vecs[0] = '{32'h0000_0000, 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000};
        vecs[1] = '{32'h0000_0010, 128'hC0DE0013_C0DE0012_C0DE0011_C0DE0010};
        vecs[2] = '{32'h0000_0FF5, 128'hC0DE0FF3_C0DE0FF2_C0DE0FF1_C0DE0FF0};
        vecs[3] = '{32'hABCD_E12F, 128'hC0DE0123_C0DE0122_C0DE0121_C0DE0120};
        vecs[4] = '{32'h0000_100C, 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000};

        rst         = 1'b1;
        mem_read_en = 1'b0;
        mem_addr    = '0;
        load_en     = 1'b0;
        load_addr   = '0;
        load_data   = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", {127'd0, mem_read_valid}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_dropped", {127'd0, req_dropped}, 128'd0);
        chk("rst_data", mem_read_data, 128'd0);

        for (int i = 0; i < NumWords; i++) begin
            load_word(32'(i * 4), pat(i / LineWords, i % LineWords));
        end

        for (int i = 0; i < 5; i++) begin
            request(vecs[i].addr, lat, d);
            check_lat($sformatf("vec%0d_lat", i), lat);
            chk($sformatf("vec%0d_data", i), d, vecs[i].exp);
        end

        // Scenario 1: fresh line 3, request mid-line address.
        load_word(32'h30, 32'h11);
        load_word(32'h34, 32'h22);
        load_word(32'h38, 32'h33);
        load_word(32'h3C, 32'h44);
        request(32'h34, lat, d);
        check_lat("s1_lat", lat);
        chk("s1_data", d, 128'h00000044_00000033_00000022_00000011);

        // Scenario 2: high address bits alias onto line 3.
        request(32'h1030, lat, d);
        check_lat("s2_lat", lat);
        chk("s2_data", d, 128'h00000044_00000033_00000022_00000011);
        chk("s2_dropped", {127'd0, req_dropped}, 128'd0);

        // Scenario 3: second strobe two cycles in is dropped, one pulse only.
        mem_read_en = 1'b1;
        mem_addr    = 32'h30;
        tick();
        mem_read_en = 1'b0;
        tick();
        mem_read_en = 1'b1;
        mem_addr    = 32'h0000_0010;
        tick();
        mem_read_en = 1'b0;
        pulses = 0;
        first  = -1;
        for (int n = 3; n <= 14; n++) begin
            tick();
            if (mem_read_valid) begin
                pulses++;
                if (first < 0) first = n;
            end
        end
        chk("s3_pulses", 128'(pulses), 128'd1);
        check_lat("s3_lat", first);
        chk("s3_dropped", {127'd0, req_dropped}, 128'd1);

`ifndef MEM_RESP_JITTER_EN
        // Scenario 4: load on the capture edge is not seen by that capture.
        mem_read_en = 1'b1;
        mem_addr    = 32'h30;
        tick();
        mem_read_en = 1'b0;
        tick();
        tick();
        tick();
        load_word(32'h34, 32'hDEADBEEF);
        chk("s4_valid", {127'd0, mem_read_valid}, 128'd1);
        chk("s4_word1_old", 128'(mem_read_data[63:32]), 128'h22);
        tick();
`else
        load_word(32'h34, 32'hDEADBEEF);
`endif
        request(32'h34, lat, d);
        chk("s4_reread", 128'(d[63:32]), 128'hDEADBEEF);

        // Scenario 5: reset mid-request abandons it but keeps the array.
        mem_read_en = 1'b1;
        mem_addr    = 32'h34;
        tick();
        mem_read_en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (mem_read_valid) pulses++;
        end
        chk("s5_pulses", 128'(pulses), 128'd0);
        chk("s5_busy", {127'd0, busy}, 128'd0);
        chk("s5_data", mem_read_data, 128'd0);
        chk("s5_dropped", {127'd0, req_dropped}, 128'd0);
        request(32'h30, lat, d);
        check_lat("s5_lat", lat);
        chk("s5_kept", d, 128'h00000044_00000033_DEADBEEF_00000011);

`ifdef MEM_RESP_JITTER_EN
        // Scenario 6: jittered latency stays within Latency..Latency+3.
        for (int i = 0; i < 100; i++) begin
            mem_addr = $urandom;
            request(mem_addr, lat, d);
            check_lat("s6_lat", lat);
            chk("s6_data", d, ref_line(mem_addr));
        end
`endif

        // Random traffic: strobes, loads and occasional resets against the model.
        for (int i = 0; i < 400; i++) begin
            mem_read_en = ($urandom_range(3) == 0);
            mem_addr    = $urandom;
            load_en     = ($urandom_range(2) == 0);
            load_addr   = $urandom;
            load_data   = $urandom;
            rst         = ($urandom_range(63) == 0);
            tick();
        end
        mem_read_en = 1'b0;
        load_en     = 1'b0;
        rst         = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
